// File: rtl/crc_frame_ctrl.sv
// Frame sequencer for a byte-wide CRC-16 engine: load, stream, finish, capture.
// Optional DATA-state stall timeout is enabled by defining CRC_TIMEOUT_EN.
module crc_frame_ctrl #(
    parameter int unsigned LEN_W       = 8,
    parameter int unsigned TIMEOUT_CYC = 255
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [LEN_W-1:0] frame_len,
    input  logic             abort,
    input  logic             in_valid,
    input  logic [7:0]       in_data,
    output logic             in_ready,
    output logic             crc_load,
    output logic             crc_en,
    output logic [7:0]       crc_in,
    output logic             d_finish,
    input  logic [7:0]       crc_out,
    output logic             busy,
    output logic             done,
    output logic [15:0]      crc_value,
    output logic             err
);

    typedef enum logic [2:0] {
        IDLE, LOAD, DATA, FINISH, CAP_HI, CAP_LO, DONE
    } state_t;

    state_t           state;
    logic [LEN_W-1:0] count;
    logic [7:0]       cap_hi;
    logic [7:0]       cap_lo;
    logic             accept;

`ifdef CRC_TIMEOUT_EN
    localparam int unsigned STALL_W = $clog2(TIMEOUT_CYC + 1);
    logic [STALL_W-1:0] stall;
`endif

    if (TIMEOUT_CYC == 0 || LEN_W == 0) begin : g_bad_param
        $error("crc_frame_ctrl: TIMEOUT_CYC and LEN_W must be non-zero");
    end

    assign accept = in_valid && in_ready;

    // Strobes are registered from the state, so each appears one cycle after
    // its state is entered; this yields the 5-cycle byte-to-done latency.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= IDLE;
            count     <= '0;
            cap_hi    <= '0;
            cap_lo    <= '0;
            in_ready  <= 1'b0;
            crc_load  <= 1'b0;
            crc_en    <= 1'b0;
            crc_in    <= '0;
            d_finish  <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            crc_value <= '0;
            err       <= 1'b0;
`ifdef CRC_TIMEOUT_EN
            stall     <= '0;
`endif
        end else begin
            crc_load <= 1'b0;
            crc_en   <= 1'b0;
            d_finish <= 1'b0;
            done     <= 1'b0;
            err      <= 1'b0;
            if (abort && state != IDLE) begin
                state    <= IDLE;
                busy     <= 1'b0;
                in_ready <= 1'b0;
            end else begin
                unique case (state)
                    IDLE: begin
                        if (start && !abort) begin
                            if (frame_len != '0) begin
                                count <= frame_len;
                                state <= LOAD;
                                busy  <= 1'b1;
                            end else begin
                                err <= 1'b1;
                            end
                        end
                    end
                    LOAD: begin
                        crc_load <= 1'b1;
                        in_ready <= 1'b1;
                        state    <= DATA;
`ifdef CRC_TIMEOUT_EN
                        stall    <= '0;
`endif
                    end
                    DATA: begin
                        if (accept) begin
                            crc_en <= 1'b1;
                            crc_in <= in_data;
                            count  <= count - 1'b1;
`ifdef CRC_TIMEOUT_EN
                            stall  <= '0;
`endif
                            if (count == LEN_W'(1)) begin
                                in_ready <= 1'b0;
                                state    <= FINISH;
                            end
                        end
`ifdef CRC_TIMEOUT_EN
                        else if (stall == STALL_W'(TIMEOUT_CYC - 1)) begin
                            err      <= 1'b1;
                            in_ready <= 1'b0;
                            busy     <= 1'b0;
                            state    <= IDLE;
                        end else begin
                            stall <= stall + 1'b1;
                        end
`endif
                    end
                    FINISH: begin
                        d_finish <= 1'b1;
                        state    <= CAP_HI;
                    end
                    CAP_HI: begin
                        cap_hi <= crc_out;
                        state  <= CAP_LO;
                    end
                    CAP_LO: begin
                        cap_lo <= crc_out;
                        state  <= DONE;
                    end
                    DONE: begin
                        // crc_value changes only together with done
                        crc_value <= {cap_hi, cap_lo};
                        done      <= 1'b1;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end
                    default: begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule
